uart_write_port: RTL and testbench



---
 rtl/uart_write_port.sv | 140 ++++++++++++++
 tb/tb_uart_write_port.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_write_port.sv
// UART transmit port: small byte FIFO fed by the CPU write handshake,
// drained by an 8N1 serialiser driving the registered TX pin.
module uart_write_port #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uartWriteReq,
    input  logic [7:0] uartWriteData,
    output logic       uartWriteReady,
    output logic       uartTx,
    output logic       uartTxBusy,
    output logic       uartTxOverflow
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    txState_t      state, stateNext;
    logic [CW-1:0] bitCnt, bitCntNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic [7:0]    shift, shiftNext;
    logic [7:0]    head;
    logic          txNext, push, pop, lastTick;

    assign uartWriteReady = (count != FULL) && !reset;
    assign push           = uartWriteReq && uartWriteReady;
    assign head           = fifoMem[rdPtr];
    assign lastTick       = (bitCnt == LAST_TICK);
    assign uartTxBusy     = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= uartWriteData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr          <= '0;
            rdPtr          <= '0;
            count          <= '0;
            uartTxOverflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (uartWriteReq && !uartWriteReady) uartTxOverflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            bitCnt <= '0;
            bitIdx <= '0;
            shift  <= '0;
            uartTx <= 1'b1;
        end else begin
            state  <= stateNext;
            bitCnt <= bitCntNext;
            bitIdx <= bitIdxNext;
            shift  <= shiftNext;
            uartTx <= txNext;
        end
    end

    // shift is consumed LSB first; tx is loaded one bit ahead so the pin stays registered
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        bitIdxNext = bitIdx;
        shiftNext  = shift;
        txNext     = uartTx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                txNext = 1'b1;
                if (count != '0) begin
                    pop        = 1'b1;
                    shiftNext  = head;
                    txNext     = 1'b0;
                    bitCntNext = '0;
                    stateNext  = START;
                end
            end
            START: begin
                if (lastTick) begin
                    bitCntNext = '0;
                    bitIdxNext = '0;
                    txNext     = shift[0];
                    stateNext  = DATA;
                end else begin
                    bitCntNext = bitCnt + CW'(1);
                end
            end
            DATA: begin
                if (lastTick) begin
                    bitCntNext = '0;
                    if (bitIdx == 3'd7) begin
                        txNext    = 1'b1;
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                        shiftNext  = {1'b0, shift[7:1]};
                        txNext     = shift[1];
                    end
                end else begin
                    bitCntNext = bitCnt + CW'(1);
                end
            end
            STOP: begin
                if (lastTick) begin
                    bitCntNext = '0;
                    if (count != '0) begin
                        pop       = 1'b1;
                        shiftNext = head;
                        txNext    = 1'b0;
                        stateNext = START;
                    end else begin
                        txNext    = 1'b1;
                        stateNext = IDLE;
                    end
                end else begin
                    bitCntNext = bitCnt + CW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_write_port.sv
// Bench for uart_write_port: vector table, directed corner sequences and
// randomized traffic checked against a frame-position reference model.
module tb_uart_write_port;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst, req, ready, tx, busy, ovf;
    logic [7:0] data;
    logic rst2, req2, ready2, tx2, busy2, ovf2;
    logic [7:0] data2;

    always #5 clk = ~clk;

    uart_write_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst), .uartWriteReq(req), .uartWriteData(data),
        .uartWriteReady(ready), .uartTx(tx), .uartTxBusy(busy), .uartTxOverflow(ovf)
    );

    uart_write_port #(.CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .reset(rst2), .uartWriteReq(req2), .uartWriteData(data2),
        .uartWriteReady(ready2), .uartTx(tx2), .uartTxBusy(busy2), .uartTxOverflow(ovf2)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: queued bytes, position within the current frame (-1 = line idle)
    logic [7:0] mq[$];
    logic [7:0] mByte = '0;
    int         mPos  = -1;
    logic       mOvf  = 1'b0;

    typedef struct {
        logic       rst;
        logic       req;
        logic [7:0] data;
        int         cycles;
        logic       tx;
        logic       busy;
        logic       ready;
        logic       ovf;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic modelTx();
        int idx;
        if (mPos < 0) return 1'b1;
        idx = mPos / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return mByte[idx-1];
    endfunction

    task automatic step(input logic r, input logic rq, input logic [7:0] d);
        logic preReady;
        logic startNew;
        rst  = r;
        req  = rq;
        data = d;
        @(posedge clk);
        preReady = !r && (mq.size() != DEPTH);
        if (r) begin
            mq.delete();
            mPos = -1;
            mOvf = 1'b0;
        end else begin
            startNew = (mPos < 0 || mPos == FRAME - 1) && (mq.size() > 0);
            if (startNew) begin
                mByte = mq.pop_front();
                mPos  = 0;
            end else if (mPos == FRAME - 1) begin
                mPos = -1;
            end else if (mPos >= 0) begin
                mPos++;
            end
            if (rq) begin
                if (preReady) mq.push_back(d);
                else mOvf = 1'b1;
            end
        end
        #1;
        check("tx", tx, modelTx());
        check("busy", busy, (mPos >= 0) || (mq.size() > 0));
        check("ready", ready, !r && (mq.size() != DEPTH));
        check("ovf", ovf, mOvf);
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((mPos >= 0 || mq.size() > 0) && n < bound) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        check(name, (mPos < 0 && mq.size() == 0), 1);
    endtask

    initial begin
        logic [7:0] a5;
        logic       allHigh;
        int         n;
        int         rate;
        a5    = 8'hA5;
        rst   = 1'b1; req = 1'b0; data = '0;
        rst2  = 1'b1; req2 = 1'b0; data2 = '0;

        // Single 0xA5 frame, CLKS_PER_BIT=4
        vecs.push_back('{1'b1, 1'b0, 8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hA5, 1, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, CPB, 1'b0, 1'b1, 1'b1, 1'b0});
        for (int b = 0; b < 8; b++)
            vecs.push_back('{1'b0, 1'b0, 8'h00, CPB, a5[b], 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, CPB, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step(vecs[i].rst, (c == 0) ? vecs[i].req : 1'b0, vecs[i].data);
                check("vecTx", tx, vecs[i].tx);
                check("vecBusy", busy, vecs[i].busy);
                check("vecReady", ready, vecs[i].ready);
                check("vecOvf", ovf, vecs[i].ovf);
            end
        end

        // Three back-to-back bytes: contiguous frames
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        drain("drain3", 200);
        check("ovfAfter3", ovf, 1'b0);

        // Six pushes from idle: fifth fills the FIFO, sixth is dropped
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h10 + 8'(i));
        check("readyFullBefore6", ready, 1'b0);
        step(1'b0, 1'b1, 8'hEE);
        check("ovfAfter6", ovf, 1'b1);
        drain("drain5", 300);
        check("ovfSticky", ovf, 1'b1);
        check("busyAfter5", busy, 1'b0);

        // Reset 15 cycles into a frame with 2 bytes queued
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'hC3);
        step(1'b0, 1'b1, 8'h99);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 8'h00);
        check("midFrameQueued", mq.size(), 2);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("rstTx", tx, 1'b1);
        check("rstBusy", busy, 1'b0);
        check("rstReady", ready, 1'b1);
        check("rstOvf", ovf, 1'b0);
        allHigh = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (tx !== 1'b1 || busy !== 1'b0) allHigh = 1'b0;
        end
        check("noFrameAfterRst", allHigh, 1'b1);

        // Full FIFO, push coinciding with the STOP->START pop is dropped
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h40 + 8'(i));
        n = 0;
        while (!(mPos == FRAME - 1 && mq.size() == DEPTH) && n < 100) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        check("reachStopFull", (mPos == FRAME - 1 && mq.size() == DEPTH), 1);
        check("readyAtStopEdge", ready, 1'b0);
        step(1'b0, 1'b1, 8'h77);
        check("ovfAtStopEdge", ovf, 1'b1);
        check("readyAfterPop", ready, 1'b1);
        step(1'b0, 1'b1, 8'h88);
        check("readyAfterPush", ready, 1'b0);
        drain("drainFull", 400);

        // Randomized traffic with varying request density and rare resets
        rate = 5;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: rate = 2;
                    1: rate = 5;
                    2: rate = 20;
                    default: rate = 60;
                endcase
            end
            step($urandom_range(0, 499) == 0, $urandom_range(0, 99) < rate, 8'($urandom));
        end
        step(1'b1, 1'b0, 8'h00);

        // CLKS_PER_BIT=2: 0xFF then 0x00
        @(posedge clk); #1;
        rst2 = 1'b0;
        @(posedge clk); #1;
        check("d2Ready", ready2, 1'b1);
        check("d2IdleTx", tx2, 1'b1);
        req2 = 1'b1; data2 = 8'hFF;
        @(posedge clk); #1;
        data2 = 8'h00;
        @(posedge clk); #1;
        req2 = 1'b0; data2 = 8'h5A;
        for (int k = 0; k < 40; k++) begin
            int bitPos;
            logic [7:0] byteV;
            logic expBit;
            bitPos = (k % 20) / 2;
            byteV  = (k < 20) ? 8'hFF : 8'h00;
            if (bitPos == 0) expBit = 1'b0;
            else if (bitPos == 9) expBit = 1'b1;
            else expBit = byteV[bitPos-1];
            check("d2Tx", tx2, expBit);
            check("d2Busy", busy2, 1'b1);
            @(posedge clk); #1;
        end
        check("d2EndTx", tx2, 1'b1);
        check("d2EndBusy", busy2, 1'b0);
        check("d2Ovf", ovf2, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
